// File: rtl/floor_request_queue.sv
// Floor-call FIFO with duplicate suppression and MMIO head/status/pop/clear for the elevator CPU.
// Optional macro FRQ_IRQ_EN adds a one-cycle irq output when the queue goes from empty to non-empty.
module floor_request_queue #(
  parameter int unsigned FLOORS    = 4,
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'd4100
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [FLOORS-1:0] req_pulse,
  input  logic [31:0]       mem_addr,
  input  logic              mem_wren,
  input  logic [31:0]       mem_data_in,
  output logic [31:0]       rd_data,
  output logic              rd_hit,
  output logic [FLOORS-1:0] pending_mask,
  output logic              empty,
  output logic              full,
`ifdef FRQ_IRQ_EN
  output logic              irq,
`endif
  output logic              overflow
);

  localparam int unsigned FW = $clog2(FLOORS + 1);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [FW-1:0]     r_fifo [DEPTH];
  logic [AW-1:0]     r_rd_ptr, r_wr_ptr;
  logic [CW-1:0]     r_count;
  logic [FLOORS-1:0] r_arrived;
  logic [FLOORS-1:0] r_pending;
  logic              r_overflow;
  logic              r_empty, r_full;
  logic [31:0]       r_rd_data;
  logic              r_rd_hit;

  logic              w_unused_data;
  logic              w_is_head, w_is_status, w_clear, w_pop;
  logic [FW-1:0]     w_head;
  logic [FLOORS-1:0] w_serv, w_pop_mask, w_pend_after;
  logic [FW-1:0]     w_k;
  logic              w_found, w_dup, w_push, w_ovf_set;
  logic [CW-1:0]     w_cnt_after, w_count_next;
  logic [31:0]       w_rd_next, w_status;
  logic              w_hit_next;

  assign w_unused_data = ^mem_data_in;

  assign w_is_head   = ~mem_wren && (mem_addr == BASE_ADDR);
  assign w_is_status = ~mem_wren && (mem_addr == BASE_ADDR + 32'd1);
  assign w_clear     =  mem_wren && (mem_addr == BASE_ADDR + 32'd3);
  assign w_pop       =  mem_wren && (mem_addr == BASE_ADDR + 32'd2) && (r_count != '0);
  assign w_head      = r_fifo[r_rd_ptr];

  // Lowest arrived floor is serviced this cycle; pop mask isolates the head's pending bit.
  always_comb begin
    w_serv     = '0;
    w_k        = '0;
    w_found    = 1'b0;
    w_pop_mask = '0;
    for (int i = 0; i < int'(FLOORS); i++) begin
      if (r_arrived[i] && !w_found) begin
        w_found   = 1'b1;
        w_serv[i] = 1'b1;
        w_k       = FW'(i + 1);
      end
      w_pop_mask[i] = w_pop && (w_head == FW'(i + 1));
    end
  end

  // Dedup and fullness are judged after any same-cycle pop; clear overrides both.
  always_comb begin
    w_pend_after = r_pending & ~w_pop_mask;
    w_cnt_after  = r_count - CW'(w_pop);
    w_dup        = (w_pend_after & w_serv) != '0;
    w_push       = w_found && !w_clear && !w_dup && (w_cnt_after != CW'(DEPTH));
    w_ovf_set    = w_found && !w_clear && !w_dup && (w_cnt_after == CW'(DEPTH));
    w_count_next = w_clear ? '0 : (w_cnt_after + CW'(w_push));
  end

  always_comb begin
    w_status         = '0;
    w_status[7:0]    = 8'(r_count);
    w_status[8]      = r_overflow;
    w_status[8+FLOORS:9] = r_pending;
    w_rd_next        = '0;
    w_hit_next       = 1'b0;
    if (w_is_head) begin
      w_hit_next = 1'b1;
      w_rd_next  = (r_count == '0) ? 32'd0 : 32'(w_head);
    end else if (w_is_status) begin
      w_hit_next = 1'b1;
      w_rd_next  = w_status;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) r_fifo[i] <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_arrived  <= '0;
      r_pending  <= '0;
      r_overflow <= 1'b0;
      r_empty    <= 1'b1;
      r_full     <= 1'b0;
      r_rd_data  <= '0;
      r_rd_hit   <= 1'b0;
    end else begin
      r_rd_data <= w_rd_next;
      r_rd_hit  <= w_hit_next;
      r_count   <= w_count_next;
      r_empty   <= (w_count_next == '0);
      r_full    <= (w_count_next == CW'(DEPTH));
      if (w_clear) begin
        r_rd_ptr   <= '0;
        r_wr_ptr   <= '0;
        r_arrived  <= req_pulse;
        r_pending  <= '0;
        r_overflow <= 1'b0;
      end else begin
        if (w_push) begin
          r_fifo[r_wr_ptr] <= w_k;
          r_wr_ptr         <= r_wr_ptr + AW'(1);
        end
        if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
        r_arrived  <= (r_arrived & ~w_serv) | req_pulse;
        r_pending  <= w_pend_after | (w_push ? w_serv : '0);
        r_overflow <= r_overflow | w_ovf_set;
      end
    end
  end

`ifdef FRQ_IRQ_EN
  logic r_irq;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_irq <= 1'b0;
    else        r_irq <= (r_count == '0) && (w_count_next != '0);
  end
  assign irq = r_irq;
`endif

  assign rd_data      = r_rd_data;
  assign rd_hit       = r_rd_hit;
  assign pending_mask = r_pending;
  assign empty        = r_empty;
  assign full         = r_full;
  assign overflow     = r_overflow;

endmodule

// File: tb/tb_floor_request_queue.sv
// Bench for floor_request_queue: a DEPTH=4 and a DEPTH=2 instance against a queue-level reference model.
module tb_floor_request_queue;

  localparam logic [31:0] B = 32'd4100;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  req      [2];
  logic [31:0] addr     [2];
  logic        wren     [2];
  logic [31:0] wdata    [2];
  logic [31:0] rd_data  [2];
  logic        rd_hit   [2];
  logic [3:0]  pend     [2];
  logic        empty    [2];
  logic        full     [2];
  logic        overflow [2];
  logic        irq      [2];

  int checks   = 0;
  int failures = 0;

  int          mq   [2][8];
  int          mcnt [2];
  logic [3:0]  marr [2];
  bit          movf [2];
  int          mdep [2];
  logic [31:0] e_rd  [2];
  bit          e_hit [2];
  bit          e_irq [2];

  always #5 clock = ~clock;

  floor_request_queue #(.FLOORS(4), .DEPTH(4), .BASE_ADDR(B)) u_dut_a (
    .clock(clock), .reset(reset), .req_pulse(req[0]), .mem_addr(addr[0]),
    .mem_wren(wren[0]), .mem_data_in(wdata[0]), .rd_data(rd_data[0]), .rd_hit(rd_hit[0]),
    .pending_mask(pend[0]), .empty(empty[0]), .full(full[0]),
`ifdef FRQ_IRQ_EN
    .irq(irq[0]),
`endif
    .overflow(overflow[0])
  );

  floor_request_queue #(.FLOORS(4), .DEPTH(2), .BASE_ADDR(B)) u_dut_b (
    .clock(clock), .reset(reset), .req_pulse(req[1]), .mem_addr(addr[1]),
    .mem_wren(wren[1]), .mem_data_in(wdata[1]), .rd_data(rd_data[1]), .rd_hit(rd_hit[1]),
    .pending_mask(pend[1]), .empty(empty[1]), .full(full[1]),
`ifdef FRQ_IRQ_EN
    .irq(irq[1]),
`endif
    .overflow(overflow[1])
  );

`ifndef FRQ_IRQ_EN
  assign irq[0] = 1'b0;
  assign irq[1] = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] m_pend(input int i);
    logic [3:0] p = '0;
    for (int j = 0; j < mcnt[i]; j++) p[mq[i][j]-1] = 1'b1;
    return p;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 2; i++) begin
      mcnt[i] = 0; marr[i] = '0; movf[i] = 0;
      e_rd[i] = '0; e_hit[i] = 0; e_irq[i] = 0;
    end
  endtask

  // Queue-level model: responses come from pre-edge state, then the edge's effects are applied.
  task automatic m_step(input int i, input logic [3:0] rq, input logic [31:0] ad, input logic wr);
    int  old;
    int  k;
    bit  dup;
    old = mcnt[i];
    e_hit[i] = 0;
    e_rd[i]  = '0;
    if (!wr && ad == B) begin
      e_hit[i] = 1;
      e_rd[i]  = (old != 0) ? 32'(mq[i][0]) : 32'd0;
    end else if (!wr && ad == B + 32'd1) begin
      e_hit[i] = 1;
      e_rd[i]  = 32'(old) + (32'(movf[i]) << 8) + (32'(m_pend(i)) << 9);
    end
    if (wr && ad == B + 32'd3) begin
      mcnt[i] = 0; movf[i] = 0; marr[i] = rq;
    end else begin
      if (wr && ad == B + 32'd2 && mcnt[i] > 0) begin
        for (int j = 0; j < mcnt[i] - 1; j++) mq[i][j] = mq[i][j+1];
        mcnt[i]--;
      end
      if (marr[i] != 0) begin
        k = 0;
        while (!marr[i][k]) k++;
        marr[i][k] = 1'b0;
        dup = 0;
        for (int j = 0; j < mcnt[i]; j++) if (mq[i][j] == k + 1) dup = 1;
        if (!dup) begin
          if (mcnt[i] < mdep[i]) begin
            mq[i][mcnt[i]] = k + 1;
            mcnt[i]++;
          end else movf[i] = 1;
        end
      end
      marr[i] = marr[i] | rq;
    end
    e_irq[i] = (old == 0) && (mcnt[i] != 0);
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rd_data%0d", i), rd_data[i], e_rd[i]);
      chk($sformatf("rd_hit%0d", i), 32'(rd_hit[i]), 32'(e_hit[i]));
      chk($sformatf("pending%0d", i), 32'(pend[i]), 32'(m_pend(i)));
      chk($sformatf("empty%0d", i), 32'(empty[i]), 32'(mcnt[i] == 0));
      chk($sformatf("full%0d", i), 32'(full[i]), 32'(mcnt[i] == mdep[i]));
      chk($sformatf("overflow%0d", i), 32'(overflow[i]), 32'(movf[i]));
`ifdef FRQ_IRQ_EN
      chk($sformatf("irq%0d", i), 32'(irq[i]), 32'(e_irq[i]));
`endif
    end
  endtask

  task automatic cycle(input logic [3:0] ra, input logic [31:0] aa, input logic wa,
                       input logic [3:0] rb, input logic [31:0] ab, input logic wb);
    req[0] = ra; addr[0] = aa; wren[0] = wa; wdata[0] = $urandom;
    req[1] = rb; addr[1] = ab; wren[1] = wb; wdata[1] = $urandom;
    @(posedge clock);
    m_step(0, ra, aa, wa);
    m_step(1, rb, ab, wb);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) cycle(4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0);
  endtask

  task automatic op_a(input logic [3:0] r, input int off, input logic w);
    cycle(r, B + 32'(off), w, 4'd0, 32'd0, 1'b0);
  endtask

  task automatic op_b(input logic [3:0] r, input int off, input logic w);
    cycle(4'd0, 32'd0, 1'b0, r, B + 32'(off), w);
  endtask

  function automatic logic [31:0] rand_addr();
    int sel = int'($urandom_range(0, 9));
    if (sel < 8) return B + 32'(sel % 4);
    return 32'($urandom);
  endfunction

  initial begin
    mdep[0] = 4;
    mdep[1] = 2;
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req[i] = '0; addr[i] = '0; wren[i] = 1'b0; wdata[i] = '0;
    end
    m_reset();
    #12;
    check_all();
    reset = 1'b1;

    // Single call to floor 3, then head and status reads.
    op_a(4'b0100, 5, 1'b0);
    idle(1);
    op_a(4'd0, 0, 1'b0);
    chk("t1_head", rd_data[0], 32'd3);
    op_a(4'd0, 1, 1'b0);
    chk("t1_status", rd_data[0], 32'h801);

    // Duplicate call to floor 2 is dropped; pop exposes floor 4.
    op_a(4'd0, 3, 1'b1);
    op_a(4'b0010, 0, 1'b1);
    op_a(4'b0010, 1, 1'b1);
    op_a(4'b1000, 9, 1'b0);
    idle(1);
    op_a(4'd0, 0, 1'b0);
    chk("t2_head", rd_data[0], 32'd2);
    op_a(4'd0, 2, 1'b1);
    op_a(4'd0, 0, 1'b0);
    chk("t2_head_after_pop", rd_data[0], 32'd4);
    op_a(4'd0, 1, 1'b0);
    chk("t2_status", rd_data[0], 32'h1001);

    // Simultaneous calls drain lowest floor first.
    op_a(4'd0, 3, 1'b1);
    op_a(4'b1011, 7, 1'b0);
    idle(3);
    for (int n = 0; n < 4; n++) begin
      op_a(4'd0, 0, 1'b0);
      chk("t3_pop_order", rd_data[0], (n == 0) ? 32'd1 : (n == 1) ? 32'd2 : (n == 2) ? 32'd4 : 32'd0);
      op_a(4'd0, 2, 1'b1);
    end

    // Shallow queue overflows on a third distinct floor; clear resets it.
    op_b(4'b0001, 7, 1'b0);
    op_b(4'b0010, 7, 1'b0);
    op_b(4'b0100, 7, 1'b0);
    idle(1);
    chk("t4_full", 32'(full[1]), 32'd1);
    chk("t4_overflow", 32'(overflow[1]), 32'd1);
    op_b(4'd0, 1, 1'b0);
    chk("t4_status", rd_data[1], 32'h702);
    op_b(4'd0, 3, 1'b1);
    chk("t4_cleared_empty", 32'(empty[1]), 32'd1);
    chk("t4_cleared_ovf", 32'(overflow[1]), 32'd0);

    // Pop of floor 1 with a fresh floor-1 call in the same cycle re-queues it.
    op_a(4'd0, 3, 1'b1);
    op_a(4'b0001, 8, 1'b0);
    idle(1);
    op_a(4'b0001, 2, 1'b1);
    idle(1);
    op_a(4'd0, 1, 1'b0);
    chk("t5_status", rd_data[0], 32'h201);

    // Clear in the same cycle as a pulse keeps the pulse.
    op_a(4'b0100, 3, 1'b1);
    idle(1);
    op_a(4'd0, 0, 1'b0);
    chk("clear_keeps_pulse", rd_data[0], 32'd3);

    // Reset mid-queue takes effect without a clock edge.
    op_a(4'b1111, 7, 1'b0);
    idle(2);
    #2;
    reset = 1'b0;
    m_reset();
    #1;
    check_all();
    @(posedge clock);
    #1;
    check_all();
    reset = 1'b1;

    // Random traffic on both instances.
    for (int c = 0; c < 600; c++) begin
      logic [3:0]  ra, rb;
      logic [31:0] aa, ab;
      logic        wa, wb;
      ra = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0;
      rb = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0;
      aa = rand_addr();
      ab = rand_addr();
      wa = 1'($urandom);
      wb = 1'($urandom);
      if (wa && aa == B + 32'd3 && $urandom_range(0, 3) != 0) wa = 1'b0;
      if (wb && ab == B + 32'd3 && $urandom_range(0, 3) != 0) wb = 1'b0;
      cycle(ra, aa, wa, rb, ab, wb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
